// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU fetch (pc) / load-store (ldst) ports, the arbiter and the unified RAM.
// slave = arbiter side, master = CPU + memory side.
interface cpu_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] i_pc_addr;
  logic          i_pc_rd;
  logic          o_pc_waitreq;
  logic [DW-1:0] o_pc_rddata;
  logic          o_pc_rdvalid;

  logic [AW-1:0] i_ldst_addr;
  logic          i_ldst_rd;
  logic          i_ldst_wr;
  logic [DW-1:0] i_ldst_wrdata;
  logic          o_ldst_waitreq;
  logic [DW-1:0] o_ldst_rddata;
  logic          o_ldst_rdvalid;

  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd;
  logic          o_mem_wr;
  logic [DW-1:0] o_mem_wrdata;
  logic [DW-1:0] i_mem_rddata;

  modport slave (
    input  i_pc_addr, i_pc_rd,
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    input  i_mem_rddata,
    output o_pc_waitreq, o_pc_rddata, o_pc_rdvalid,
    output o_ldst_waitreq, o_ldst_rddata, o_ldst_rdvalid,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
  );

  modport master (
    output i_pc_addr, i_pc_rd,
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    output i_mem_rddata,
    input  o_pc_waitreq, o_pc_rddata, o_pc_rdvalid,
    input  o_ldst_waitreq, o_ldst_rddata, o_ldst_rdvalid,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter for CPU fetch (pc) and load/store ports with 1-cycle read return routing.
// Define CPU_MEM_ARB_RR_EN for round-robin on contention; default is fixed priority (ldst wins).
module cpu_mem_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  cpu_mem_arbiter_if.slave bus,
  output logic [CNT_W-1:0] o_conflict_cnt
);

  typedef struct packed {
    logic vld;
    logic own_ldst;
  } tag_t;

  logic w_pc_req, w_ldst_req, w_both;
  logic w_ldst_wins;
  logic w_gnt_pc, w_gnt_ldst;
  logic w_mem_rd, w_mem_wr;
  tag_t r_tag;
  logic [CNT_W-1:0] r_cnt;

  assign w_pc_req   = bus.i_pc_rd;
  assign w_ldst_req = bus.i_ldst_rd | bus.i_ldst_wr;
  assign w_both     = w_pc_req & w_ldst_req;

`ifdef CPU_MEM_ARB_RR_EN
  // 1 = ldst took the last contended grant, so pc is owed the next one
  logic r_last_ldst;

  always_ff @(posedge clk) begin
    if (reset)
      r_last_ldst <= 1'b0;
    else if (w_both)
      r_last_ldst <= w_gnt_ldst;
  end

  assign w_ldst_wins = ~r_last_ldst;
`else
  assign w_ldst_wins = 1'b1;
`endif

  always_comb begin
    w_gnt_ldst = 1'b0;
    w_gnt_pc   = 1'b0;
    if (!reset) begin
      w_gnt_ldst = w_ldst_req & (~w_pc_req | w_ldst_wins);
      w_gnt_pc   = w_pc_req & ~w_gnt_ldst;
    end
  end

  // write beats read when ldst raises both strobes
  assign w_mem_wr = w_gnt_ldst & bus.i_ldst_wr;
  assign w_mem_rd = w_gnt_pc | (w_gnt_ldst & ~bus.i_ldst_wr);

  always_comb begin
    bus.o_mem_addr   = bus.i_pc_addr;
    bus.o_mem_wrdata = bus.i_ldst_wrdata;
    bus.o_mem_rd     = w_mem_rd;
    bus.o_mem_wr     = w_mem_wr;
    if (w_gnt_ldst)
      bus.o_mem_addr = bus.i_ldst_addr;
  end

  assign bus.o_pc_waitreq   = reset | (w_pc_req & ~w_gnt_pc);
  assign bus.o_ldst_waitreq = reset | (w_ldst_req & ~w_gnt_ldst);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag.vld      <= w_mem_rd;
      r_tag.own_ldst <= w_gnt_ldst;
    end
  end

  // gating with reset drops a read whose data lands in a reset cycle
  assign bus.o_pc_rdvalid   = ~reset & r_tag.vld & ~r_tag.own_ldst;
  assign bus.o_ldst_rdvalid = ~reset & r_tag.vld & r_tag.own_ldst;
  assign bus.o_pc_rddata    = bus.i_mem_rddata;
  assign bus.o_ldst_rddata  = bus.i_mem_rddata;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_both && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_conflict_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter; a second instance with a 3-bit counter covers saturation.
module tb_cpu_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;
  int checks = 0;
  int errors = 0;

  cpu_mem_arbiter_if #(.AW(16), .DW(16)) bus ();
  cpu_mem_arbiter_if #(.AW(16), .DW(16)) bus_s ();

  assign bus_s.i_pc_addr     = bus.i_pc_addr;
  assign bus_s.i_pc_rd       = bus.i_pc_rd;
  assign bus_s.i_ldst_addr   = bus.i_ldst_addr;
  assign bus_s.i_ldst_rd     = bus.i_ldst_rd;
  assign bus_s.i_ldst_wr     = bus.i_ldst_wr;
  assign bus_s.i_ldst_wrdata = bus.i_ldst_wrdata;
  assign bus_s.i_mem_rddata  = bus.i_mem_rddata;

  cpu_mem_arbiter #(.AW(16), .DW(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .o_conflict_cnt(cnt)
  );

  cpu_mem_arbiter #(.AW(16), .DW(16), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_s), .o_conflict_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef CPU_MEM_ARB_RR_EN
  localparam logic [4:0] EXP_LDST = 5'b10101;
`else
  localparam logic [4:0] EXP_LDST = 5'b11111;
`endif

  initial begin
    logic [4:0] exp_ldst;
    exp_ldst = EXP_LDST;
    reset = 1'b1;
    bus.i_pc_addr = 16'h0; bus.i_pc_rd = 1'b1;
    bus.i_ldst_addr = 16'h0; bus.i_ldst_rd = 1'b1; bus.i_ldst_wr = 1'b0;
    bus.i_ldst_wrdata = 16'h0; bus.i_mem_rddata = 16'h0;

    // reset with both requesting: nothing granted, nothing counted
    tick(); tick(); #1;
    chk("rst_pc_wait",   bus.o_pc_waitreq, 1);
    chk("rst_ldst_wait", bus.o_ldst_waitreq, 1);
    chk("rst_mem_rd",    bus.o_mem_rd, 0);
    chk("rst_mem_wr",    bus.o_mem_wr, 0);
    chk("rst_cnt",       cnt, 0);
    chk("rst_pc_rdv",    bus.o_pc_rdvalid, 0);
    chk("rst_ldst_rdv",  bus.o_ldst_rdvalid, 0);
    bus.i_pc_rd = 1'b0; bus.i_ldst_rd = 1'b0;
    tick();
    reset = 1'b0;
    #1;

    // pc-only fetch
    bus.i_pc_rd = 1'b1; bus.i_pc_addr = 16'h0010; #1;
    chk("t1_mem_rd",   bus.o_mem_rd, 1);
    chk("t1_mem_addr", bus.o_mem_addr, 16'h0010);
    chk("t1_pc_wait",  bus.o_pc_waitreq, 0);
    tick();
    bus.i_pc_rd = 1'b0; bus.i_mem_rddata = 16'hA5A5; #1;
    chk("t1_pc_rdv",   bus.o_pc_rdvalid, 1);
    chk("t1_pc_data",  bus.o_pc_rddata, 16'hA5A5);
    chk("t1_ldst_rdv", bus.o_ldst_rdvalid, 0);
    chk("t1_cnt",      cnt, 0);

    // contention: ldst write wins first contention in either build
    bus.i_pc_rd = 1'b1; bus.i_pc_addr = 16'h0004;
    bus.i_ldst_wr = 1'b1; bus.i_ldst_addr = 16'h0200; bus.i_ldst_wrdata = 16'h1234; #1;
    chk("t2_mem_wr",   bus.o_mem_wr, 1);
    chk("t2_mem_rd",   bus.o_mem_rd, 0);
    chk("t2_mem_addr", bus.o_mem_addr, 16'h0200);
    chk("t2_wrdata",   bus.o_mem_wrdata, 16'h1234);
    chk("t2_pc_wait",  bus.o_pc_waitreq, 1);
    chk("t2_ldst_wait", bus.o_ldst_waitreq, 0);
    tick();
    bus.i_ldst_wr = 1'b0; #1;
    chk("t2_pc_gnt",   bus.o_mem_rd, 1);
    chk("t2_pc_addr",  bus.o_mem_addr, 16'h0004);
    chk("t2_pc_wait2", bus.o_pc_waitreq, 0);
    chk("t2_no_rdv",   bus.o_pc_rdvalid | bus.o_ldst_rdvalid, 0);
    chk("t2_cnt",      cnt, 1);
    tick();
    bus.i_pc_rd = 1'b0; bus.i_mem_rddata = 16'h5A5A; #1;
    chk("t2_pc_rdv",   bus.o_pc_rdvalid, 1);
    chk("t2_pc_data",  bus.o_pc_rddata, 16'h5A5A);

    // back-to-back ldst read then pc read
    bus.i_ldst_rd = 1'b1; bus.i_ldst_addr = 16'h0100; #1;
    chk("t3_mem_addr", bus.o_mem_addr, 16'h0100);
    chk("t3_ldst_wait", bus.o_ldst_waitreq, 0);
    tick();
    bus.i_ldst_rd = 1'b0; bus.i_pc_rd = 1'b1; bus.i_pc_addr = 16'h0000;
    bus.i_mem_rddata = 16'h1111; #1;
    chk("t3_ldst_rdv",  bus.o_ldst_rdvalid, 1);
    chk("t3_ldst_data", bus.o_ldst_rddata, 16'h1111);
    chk("t3_pc_rdv0",   bus.o_pc_rdvalid, 0);
    chk("t3_pc_wait",   bus.o_pc_waitreq, 0);
    chk("t3_pc_addr",   bus.o_mem_addr, 16'h0000);
    tick();
    bus.i_pc_rd = 1'b0; bus.i_mem_rddata = 16'h2222; #1;
    chk("t3_pc_rdv",    bus.o_pc_rdvalid, 1);
    chk("t3_pc_data",   bus.o_pc_rddata, 16'h2222);
    chk("t3_ldst_rdv0", bus.o_ldst_rdvalid, 0);

    // reset lands on the return cycle of a granted ldst read
    bus.i_ldst_rd = 1'b1; bus.i_ldst_addr = 16'h0300; #1;
    chk("t4_mem_rd", bus.o_mem_rd, 1);
    tick();
    bus.i_ldst_rd = 1'b0; reset = 1'b1; #1;
    chk("t4_ldst_rdv", bus.o_ldst_rdvalid, 0);
    chk("t4_pc_wait",  bus.o_pc_waitreq, 1);
    chk("t4_ldst_wait", bus.o_ldst_waitreq, 1);
    tick(); #1;
    chk("t4_cnt",       cnt, 0);
    chk("t4_ldst_rdv2", bus.o_ldst_rdvalid, 0);
    reset = 1'b0;

    // five contended cycles
    bus.i_pc_rd = 1'b1; bus.i_pc_addr = 16'h0040;
    bus.i_ldst_rd = 1'b1; bus.i_ldst_addr = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_addr_%0d", i), bus.o_mem_addr, exp_ldst[i] ? 16'h0080 : 16'h0040);
      chk($sformatf("t5_pcw_%0d", i),  bus.o_pc_waitreq, {31'b0, exp_ldst[i]});
      chk($sformatf("t5_lsw_%0d", i),  bus.o_ldst_waitreq, {31'b0, ~exp_ldst[i]});
      tick();
    end
    bus.i_pc_rd = 1'b0; bus.i_ldst_rd = 1'b0; #1;
    chk("t5_cnt",   cnt, 5);
    chk("t5_cnt_s", cnt_s, 5);

    // write wins over read on the same port
    bus.i_ldst_rd = 1'b1; bus.i_ldst_wr = 1'b1;
    bus.i_ldst_addr = 16'h0400; bus.i_ldst_wrdata = 16'hBEEF; #1;
    chk("t6_mem_wr",  bus.o_mem_wr, 1);
    chk("t6_mem_rd",  bus.o_mem_rd, 0);
    chk("t6_wrdata",  bus.o_mem_wrdata, 16'hBEEF);
    tick();
    bus.i_ldst_rd = 1'b0; bus.i_ldst_wr = 1'b0; #1;
    chk("t6_ldst_rdv", bus.o_ldst_rdvalid, 0);
    chk("t6_pc_rdv",   bus.o_pc_rdvalid, 0);

    // saturation on the 3-bit counter: 5 -> 7 then held
    bus.i_pc_rd = 1'b1; bus.i_ldst_rd = 1'b1;
    tick(); tick(); #1;
    chk("sat_cnt_7",   cnt, 7);
    chk("sat_cnt_s_7", cnt_s, 7);
    tick(); tick(); #1;
    chk("sat_cnt_9",    cnt, 9);
    chk("sat_cnt_s_hold", cnt_s, 7);
    bus.i_pc_rd = 1'b0; bus.i_ldst_rd = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Shares one single-port memory between the CPU instruction-fetch port (pc, read-only) and the load/store port (ldst, read/write).
- Grants at most one access per cycle to the memory and stalls the loser with waitrequest.
- Routes 1-cycle-latency read data back to whichever requester issued the read.
- Sits between the CPU's pc/ldst ports and a unified instruction/data RAM.

Parameters:
AW, 16, address width.
DW, 16, data width.
CNT_W, 16, width of the saturating conflict counter.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
i_pc_addr  in  AW  fetch address.
i_pc_rd  in  1  fetch read request.
o_pc_waitreq  out  1  fetch stalled this cycle; requester holds addr/rd.
o_pc_rddata  out  DW  fetch read data.
o_pc_rdvalid  out  1  o_pc_rddata valid.
i_ldst_addr  in  AW  load/store address.
i_ldst_rd  in  1  load request.
i_ldst_wr  in  1  store request.
i_ldst_wrdata  in  DW  store data.
o_ldst_waitreq  out  1  load/store stalled this cycle.
o_ldst_rddata  out  DW  load read data.
o_ldst_rdvalid  out  1  o_ldst_rddata valid.
o_mem_addr  out  AW  memory address.
o_mem_rd  out  1  memory read strobe.
o_mem_wr  out  1  memory write strobe.
o_mem_wrdata  out  DW  memory write data.
i_mem_rddata  in  DW  memory read data; valid exactly 1 cycle after o_mem_rd.
o_conflict_cnt  out  CNT_W  count of cycles where both ports requested.

Behaviour:
Reset:
- Reset is synchronous, active-high, on clk.
- On reset: rdvalid outputs=0, return tag cleared, o_conflict_cnt=0, last-grant register=pc.
- While reset is high: no grants, o_mem_rd=o_mem_wr=0, both waitreq=1 (combinationally gated).

Requests:
- pc_req = i_pc_rd.
- ldst_req = i_ldst_rd | i_ldst_wr.
- If i_ldst_rd and i_ldst_wr are both high, the write wins and the read is ignored for that grant.

Arbitration (combinational, same cycle):
- Only one port requests: that port is granted; its waitreq=0.
- Both request: the arbitration policy picks the winner. The loser's waitreq=1; it holds its inputs and retries next cycle.
- Non-requesting port: waitreq=0 (don't-care for the requester).
- Default policy: ldst always wins.
- Grant drives o_mem_addr/o_mem_rd/o_mem_wr/o_mem_wrdata from the granted port.
- No grant: o_mem_rd=o_mem_wr=0; o_mem_addr/o_mem_wrdata hold the pc values (don't-care).

Issue rate and read return:
- No idle cycle is required between grants; back-to-back issue every cycle is allowed.
- Return tag register (2 bits: valid, owner) is loaded each cycle with {granted read, owner}. A granted write loads valid=0.
- Cycle T+1 after a read granted at T: owner's rdvalid=1 and its rddata=i_mem_rddata. The other port's rdvalid=0.
- rddata outputs are a direct pass of i_mem_rddata; meaningful only when rdvalid=1.
- Reset asserted at T+1 with a read in flight: rdvalid stays 0 and the data is dropped.

Conflict counter:
- Increments by 1 in any non-reset cycle with pc_req & ldst_req.
- Saturates at all-ones and does not wrap.

Latency:
- Read: request to rdvalid = 1 cycle when uncontended; +1 per lost arbitration cycle.
- Write: completes in the grant cycle.

Optional Feature:
Macro CPU_MEM_ARB_RR_EN.
- Defined: round-robin on contention. A 1-bit last-grant register updates on every contended grant, and the port not granted at the last contention wins. An uncontended grant does not update it. Reset value = pc, so the first contention goes to ldst.
- Undefined: fixed priority, ldst wins. The last-grant register is not built.
- All other behaviour is identical.

Test Plan:
- Reset then pc-only fetch, addr 0x0010, memory returns 0xA5A5 -> o_mem_rd=1 at T; o_pc_rdvalid=1 with 0xA5A5 at T+1; o_ldst_rdvalid=0; o_conflict_cnt=0.
- pc reads 0x0004 while ldst writes 0x1234 to 0x0200 in the same cycle (fixed priority) -> T: o_mem_wr=1, addr 0x0200, o_pc_waitreq=1. T+1: pc granted. T+2: o_pc_rdvalid=1. o_conflict_cnt=1.
- Back-to-back: ldst read 0x0100 at T, pc read 0x0000 at T+1 -> o_ldst_rdvalid at T+1, o_pc_rdvalid at T+2; no stall cycles.
- Reset asserted the cycle after a granted ldst read -> o_ldst_rdvalid stays 0; o_conflict_cnt=0; both waitreq=1 during reset.
- Both ports request continuously for 5 cycles with CPU_MEM_ARB_RR_EN -> grants alternate ldst, pc, ldst, pc, ldst; o_conflict_cnt=5. Without the macro, ldst is granted all 5 and pc waitreq stays 1.
- i_ldst_rd=i_ldst_wr=1 on an uncontended cycle -> o_mem_wr=1, o_mem_rd=0, no o_ldst_rdvalid at T+1; preset counter to 0xFFFF and contend -> stays 0xFFFF.
